// File: rtl/scan_pkg.sv
// Shared types for the scan-pad initiator: command opcodes, FSM states,
// bit-slot phases, the registered pad bundle and opcode helper functions.
package scan_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_XCHG  = 2'b11
  } scan_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_SHIFT,
    ST_LOAD,
    ST_RESP
  } scan_state_e;

  // One bit slot walks through these four phases in order.
  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PHI,
    PH_GAP,
    PH_PHIB
  } scan_phase_e;

  // Pad outputs that are recomputed every cycle (scan_id is held separately).
  typedef struct packed {
    logic phi;
    logic phi_bar;
    logic data_in;
    logic load_chip;
    logic load_chain;
  } scan_pads_t;

  // Opcodes that capture the chip registers and return chain contents.
  function automatic logic op_reads(scan_op_e op);
    return (op == OP_READ) || (op == OP_XCHG);
  endfunction

  // Opcodes that commit the shifted chain into the chip registers.
  function automatic logic op_writes(scan_op_e op);
    return (op == OP_WRITE) || (op == OP_XCHG);
  endfunction

endpackage

// File: rtl/scan_phase_gen.sv
// Phase timer and sequencer for one scan bit slot.
// Each phase lasts PHASE_CYC clocks; phases advance SETUP -> PHI -> GAP -> PHIB
// and wrap. While en is low the sequencer is parked at SETUP with the timer at 0,
// so every enabled run starts at the beginning of a slot.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          run the sequencer (low: park at SETUP)
//   phase       current phase
//   phase_last  high on the last clock of the current phase
module scan_phase_gen
  import scan_pkg::*;
#(
  parameter int unsigned PHASE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output scan_phase_e phase,
  output logic        phase_last
);

  localparam int unsigned TMR_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  scan_phase_e      phase_d;

  // Next timer/phase; phase_last is kept equal to (timer_q == PHASE_CYC-1).
  always_comb begin
    timer_d = '0;
    phase_d = PH_SETUP;
    if (en) begin
      if (phase_last) begin
        timer_d = '0;
        phase_d = scan_phase_e'(2'(phase) + 2'd1);
      end else begin
        timer_d = timer_q + TMR_W'(1);
        phase_d = phase;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q    <= '0;
      phase      <= PH_SETUP;
      phase_last <= (PHASE_CYC == 1);
    end else begin
      timer_q    <= timer_d;
      phase      <= phase_d;
      phase_last <= (timer_d == TMR_W'(PHASE_CYC - 1));
    end
  end

endmodule

// File: rtl/scan_master.sv
// Initiator for the chip scan-pad protocol. Converts one WRITE / READ / XCHG
// command into two-phase non-overlapping shift sequences on the scan pads and
// returns the captured chain through a valid/ready response.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE, no pending rsp)
//   cmd_op/cmd_id/cmd_wdata     opcode, chain select, data to shift (bit0 first)
//   rsp_valid/rsp_ready         response handshake, held until consumed
//   rsp_rdata                   captured chain, bit k = k-th sampled scan_data_out
//   scan_id, scan_phi, scan_phi_bar, scan_data_in,
//   scan_load_chip, scan_load_chain   pad outputs (all registered)
//   scan_data_out               serial data from the chip
// Build option: SCAN_MASTER_ABORT_EN adds input abort, which returns any active
// (non-IDLE, non-RESP) command to IDLE on the next clock with pads low and no response.
module scan_master
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned PHASE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic                 cmd_id,
  input  logic [CHAIN_LEN-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_rdata,
  output logic                 scan_id,
  output logic                 scan_phi,
  output logic                 scan_phi_bar,
  output logic                 scan_data_in,
  input  logic                 scan_data_out,
  output logic                 scan_load_chip,
  output logic                 scan_load_chain
`ifdef SCAN_MASTER_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned IDX_W = $clog2(CHAIN_LEN);

  scan_state_e          state_q;
  scan_state_e          state_d;
  scan_op_e             op_q;
  logic [CHAIN_LEN-1:0] wdata_q;
  logic [CNT_W-1:0]     bit_q;
  logic [CNT_W-1:0]     bit_d;
  logic                 sample_q;
  logic                 sample_d;
  logic                 rsp_valid_d;
  scan_pads_t           pads_d;
  scan_phase_e          phase;
  logic                 phase_last;
  logic                 accept_c;
  logic                 abort_c;
  logic                 slot_end_c;
  logic [IDX_W-1:0]     idx_c;

  assign accept_c   = cmd_valid && cmd_ready;
  assign slot_end_c = (phase == PH_PHIB) && phase_last;
  assign idx_c      = bit_q[IDX_W-1:0];

`ifdef SCAN_MASTER_ABORT_EN
  assign abort_c = abort && (state_q != ST_IDLE) && (state_q != ST_RESP);
`else
  assign abort_c = 1'b0;
`endif

  // Slot timing runs only while pads are being exercised.
  scan_phase_gen #(
    .PHASE_CYC (PHASE_CYC)
  ) u_phase_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         ((state_q == ST_CAPT) || (state_q == ST_SHIFT) || (state_q == ST_LOAD)),
    .phase      (phase),
    .phase_last (phase_last)
  );

  // Next state, bit counter, response flag and next pad values.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    sample_d    = 1'b0;
    rsp_valid_d = rsp_valid;
    pads_d      = '0;

    unique case (state_q)
      ST_IDLE: begin
        bit_d = '0;
        if (accept_c) begin
          unique case (scan_op_e'(cmd_op))
            OP_NOP:   state_d = ST_RESP;
            OP_WRITE: state_d = ST_SHIFT;
            default:  state_d = ST_CAPT;
          endcase
        end
      end
      ST_CAPT: begin
        pads_d.load_chain = 1'b1;
        if (slot_end_c) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        pads_d.data_in = wdata_q[idx_c];
        pads_d.phi     = (phase == PH_PHI);
        pads_d.phi_bar = (phase == PH_PHIB);
        // Sample on the clock where the pads show the last SETUP clock.
        sample_d = op_reads(op_q) && (phase == PH_SETUP) && phase_last;
        if (slot_end_c) begin
          if (bit_q == CNT_W'(CHAIN_LEN - 1)) begin
            state_d = op_writes(op_q) ? ST_LOAD : ST_RESP;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      ST_LOAD: begin
        // SETUP/PHI/GAP of the sequencer stand in for GAP/load_chip/GAP.
        pads_d.load_chip = (phase == PH_PHI);
        if ((phase == PH_GAP) && phase_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!rsp_valid) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_c) begin
      state_d  = ST_IDLE;
      sample_d = 1'b0;
      pads_d   = '0;
    end
  end

  // FSM state and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      sample_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      sample_q <= sample_d;
    end
  end

  // Registered pads and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      scan_phi        <= 1'b0;
      scan_phi_bar    <= 1'b0;
      scan_data_in    <= 1'b0;
      scan_load_chip  <= 1'b0;
      scan_load_chain <= 1'b0;
    end else begin
      cmd_ready       <= (state_d == ST_IDLE);
      rsp_valid       <= rsp_valid_d;
      scan_phi        <= pads_d.phi;
      scan_phi_bar    <= pads_d.phi_bar;
      scan_data_in    <= pads_d.data_in;
      scan_load_chip  <= pads_d.load_chip;
      scan_load_chain <= pads_d.load_chain;
    end
  end

  // Command capture and serial read-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_NOP;
      wdata_q   <= '0;
      scan_id   <= 1'b0;
      rsp_rdata <= '0;
    end else if (accept_c) begin
      op_q      <= scan_op_e'(cmd_op);
      wdata_q   <= (scan_op_e'(cmd_op) == OP_READ) ? '0 : cmd_wdata;
      scan_id   <= cmd_id;
      rsp_rdata <= '0;
    end else if (sample_q) begin
      rsp_rdata[idx_c] <= scan_data_out;
    end
  end

endmodule

// File: tb/tb_scan_master.sv
// Directed bench for scan_master (CHAIN_LEN=8, PHASE_CYC=2) with a behavioural
// chip scan chain: master latch on phi, shift toward bit0 on each phi_bar pulse,
// capture on load_chain, commit on load_chip.
module tb_scan_master;
  import scan_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned P = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic         cmd_id = 1'b0;
  logic [N-1:0] cmd_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_rdata;
  logic         scan_id, scan_phi, scan_phi_bar, scan_data_in;
  logic         scan_data_out, scan_load_chip, scan_load_chain;
`ifdef SCAN_MASTER_ABORT_EN
  logic         abort = 1'b0;
`endif

  scan_master #(.CHAIN_LEN(N), .PHASE_CYC(P)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_id          (cmd_id),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .scan_id         (scan_id),
    .scan_phi        (scan_phi),
    .scan_phi_bar    (scan_phi_bar),
    .scan_data_in    (scan_data_in),
    .scan_data_out   (scan_data_out),
    .scan_load_chip  (scan_load_chip),
    .scan_load_chain (scan_load_chain)
`ifdef SCAN_MASTER_ABORT_EN
    ,
    .abort           (abort)
`endif
  );

  always #5 clk = ~clk;

  // Chip-side scan chain model.
  logic [N-1:0] chip_chain = '0;
  logic [N-1:0] chip_regs  = '0;
  logic         chip_master = 1'b0;
  logic         phib_prev = 1'b0;

  always @(posedge clk) begin
    phib_prev <= scan_phi_bar;
    if (scan_phi) chip_master <= scan_data_in;
    if (scan_phi_bar && !phib_prev) chip_chain <= {chip_master, chip_chain[N-1:1]};
    if (scan_load_chain) chip_chain <= chip_regs;
    if (scan_load_chip) chip_regs <= chip_chain;
  end
  assign scan_data_out = chip_chain[0];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Results of the last do_cmd.
  int           lat, n_phi, n_phib, n_chip, n_chain, ovl, bp_err;
  logic [N-1:0] seq, rd;
  logic         post_valid, post_ready;

  function automatic logic [5:0] pads();
    return {scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain};
  endfunction

  task automatic issue(input logic [1:0] op, input logic id, input logic [N-1:0] wd);
    @(negedge clk);
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_id = id; cmd_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_wdata = '0;
  endtask

  // Issue a command, watch the pads until rsp_valid, hold backpressure, consume.
  task automatic do_cmd(input logic [1:0] op, input logic id, input logic [N-1:0] wd, input int hold);
    logic pphi, pphib, pdin;
    issue(op, id, wd);
    n_phi = 0; n_phib = 0; n_chip = 0; n_chain = 0; ovl = 0; bp_err = 0; seq = '0;
    pphi = 1'b0; pphib = 1'b0; pdin = scan_data_in;
    lat = 0;
    while (!rsp_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (scan_phi && scan_phi_bar) ovl++;
      if ((scan_phi || scan_phi_bar) && (scan_data_in != pdin)) ovl++;
      if (scan_phi && !pphi) begin
        if (n_phi < int'(N)) seq[n_phi] = scan_data_in;
        n_phi++;
      end
      if (scan_phi_bar && !pphib) n_phib++;
      if (scan_load_chip) n_chip++;
      if (scan_load_chain) n_chain++;
      pphi = scan_phi; pphib = scan_phi_bar; pdin = scan_data_in;
    end
    rd = rsp_rdata;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!rsp_valid || cmd_ready || rsp_rdata != rd) bp_err++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    post_valid = rsp_valid;
    post_ready = cmd_ready;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_pads", 32'(pads()), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // WRITE A5: data_in sequence, pulse counts, one 2-clock load_chip pulse.
    do_cmd(OP_WRITE, 1'b1, 8'hA5, 0);
    check("wr_latency", 32'(lat), 32'd71);
    check("wr_phi_pulses", 32'(n_phi), 32'd8);
    check("wr_phib_pulses", 32'(n_phib), 32'd8);
    check("wr_din_seq", 32'(seq), 32'hA5);
    check("wr_load_chip_clks", 32'(n_chip), 32'd2);
    check("wr_load_chain_clks", 32'(n_chain), 32'd0);
    check("wr_rdata", 32'(rd), 32'd0);
    check("wr_overlap", 32'(ovl), 32'd0);
    check("wr_chip_regs", 32'(chip_regs), 32'hA5);
    check("wr_scan_id", 32'(scan_id), 32'd1);
    check("wr_rsp_dropped", 32'(post_valid), 32'd0);
    check("wr_ready_again", 32'(post_ready), 32'd1);

    // READ returns chip registers 3C; wdata ignored (data_in held 0).
    do_cmd(OP_WRITE, 1'b0, 8'h3C, 0);
    check("wr2_chip_regs", 32'(chip_regs), 32'h3C);
    do_cmd(OP_READ, 1'b0, 8'hFF, 0);
    check("rd_latency", 32'(lat), 32'd73);
    check("rd_rdata", 32'(rd), 32'h3C);
    check("rd_load_chain_clks", 32'(n_chain), 32'd8);
    check("rd_load_chip_clks", 32'(n_chip), 32'd0);
    check("rd_din_seq", 32'(seq), 32'h00);
    check("rd_phi_pulses", 32'(n_phi), 32'd8);
    check("rd_overlap", 32'(ovl), 32'd0);
    check("rd_scan_id", 32'(scan_id), 32'd0);
    check("rd_chip_regs_kept", 32'(chip_regs), 32'h3C);

    // XCHG FF against chip registers 0F.
    do_cmd(OP_WRITE, 1'b1, 8'h0F, 0);
    do_cmd(OP_XCHG, 1'b1, 8'hFF, 0);
    check("xc_latency", 32'(lat), 32'd79);
    check("xc_rdata", 32'(rd), 32'h0F);
    check("xc_chip_regs", 32'(chip_regs), 32'hFF);
    check("xc_load_chain_clks", 32'(n_chain), 32'd8);
    check("xc_load_chip_clks", 32'(n_chip), 32'd2);
    check("xc_din_seq", 32'(seq), 32'hFF);
    check("xc_overlap", 32'(ovl), 32'd0);

    // Backpressure: response held 20 clocks.
    do_cmd(OP_READ, 1'b0, 8'h00, 20);
    check("bp_rdata", 32'(rd), 32'hFF);
    check("bp_hold_errors", 32'(bp_err), 32'd0);
    check("bp_rsp_dropped", 32'(post_valid), 32'd0);
    check("bp_ready_again", 32'(post_ready), 32'd1);

    // NOP: response one clock after accept, no pad activity.
    do_cmd(OP_NOP, 1'b0, 8'h77, 0);
    check("nop_latency", 32'(lat), 32'd1);
    check("nop_rdata", 32'(rd), 32'd0);
    check("nop_activity", 32'(n_phi + n_phib + n_chip + n_chain), 32'd0);

    // Async reset mid-SHIFT, then a clean WRITE.
    issue(OP_WRITE, 1'b1, 8'h00);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pads", 32'(pads()), 32'd0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    do_cmd(OP_WRITE, 1'b1, 8'h5A, 0);
    check("post_rst_latency", 32'(lat), 32'd71);
    check("post_rst_din_seq", 32'(seq), 32'h5A);
    check("post_rst_chip_regs", 32'(chip_regs), 32'h5A);
    do_cmd(OP_READ, 1'b0, 8'h00, 0);
    check("post_rst_rdata", 32'(rd), 32'h5A);

`ifdef SCAN_MASTER_ABORT_EN
    // Abort during bit 3 of an XCHG: pads low next clock, IDLE, no response.
    issue(OP_XCHG, 1'b1, 8'h00);
    repeat (34) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_pads", 32'(pads() & 6'b011111), 32'd0);
    check("abort_scan_id_held", 32'(scan_id), 32'd1);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    do_cmd(OP_READ, 1'b0, 8'h00, 0);
    check("abort_regs_untouched", 32'(rd), 32'h5A);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
